// File: rtl/if_pc_bpu_if.sv
`default_nettype none
// ============================================================================
// Module   : if_pc_bpu_if
// Brief    : Fetch-PC / branch-predictor bus (EX feedback in, fetch PC out).
// Revision : 1.0 - initial release
// ============================================================================
interface if_pc_bpu_if;
    logic        stall;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        ex_upd_valid;
    logic [31:0] ex_upd_pc;
    logic        ex_upd_taken;
    logic [31:0] ex_upd_target;
    logic        ex_upd_is_jal;
    logic        ex_upd_is_jalr;
    logic [31:0] if_pc;
    logic        predict_taken;
    logic [31:0] branch_predict_pc;

    modport master (
        output stall, ex_redirect, ex_redirect_pc,
        output ex_upd_valid, ex_upd_pc, ex_upd_taken, ex_upd_target,
        output ex_upd_is_jal, ex_upd_is_jalr,
        input  if_pc, predict_taken, branch_predict_pc
    );

    modport slave (
        input  stall, ex_redirect, ex_redirect_pc,
        input  ex_upd_valid, ex_upd_pc, ex_upd_taken, ex_upd_target,
        input  ex_upd_is_jal, ex_upd_is_jalr,
        output if_pc, predict_taken, branch_predict_pc
    );
endinterface
`default_nettype wire

// File: rtl/if_pc_bpu.sv
`default_nettype none
// ============================================================================
// Module   : if_pc_bpu
// Brief    : Fetch PC generator with direct-mapped BTB and 2-bit counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_pc_bpu #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    if_pc_bpu_if.slave     bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [1:0] c_cnt_init = 2'b01;
    localparam logic [1:0] c_cnt_jal  = 2'b11;
    localparam logic [1:0] c_cnt_br   = 2'b10;

    logic [31:0]            r_pc;
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
    logic [29:0]            r_target [BTB_ENTRIES];
    logic [1:0]             r_cnt    [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic             w_lk_hit;
    logic             w_pred_taken;
    logic [31:0]      w_pred_pc;

    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_ent_we;
    logic             w_ent_valid;
    logic [TAG_W-1:0] w_ent_tag;
    logic [29:0]      w_ent_target;
    logic [1:0]       w_ent_cnt;
    logic             w_unused;

    // Lookup reads the array as it stood before this edge's update.
    assign w_lk_idx     = r_pc[IDX_W+1:2];
    assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == r_pc[31:IDX_W+2]);
    assign w_pred_taken = w_lk_hit && r_cnt[w_lk_idx][1];
    assign w_pred_pc    = w_pred_taken ? {r_target[w_lk_idx], 2'b00} : (r_pc + 32'd4);

    assign w_up_idx = bus.ex_upd_pc[IDX_W+1:2];
    assign w_up_tag = bus.ex_upd_pc[31:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    always_comb begin
        w_ent_we     = 1'b0;
        w_ent_valid  = r_valid[w_up_idx];
        w_ent_tag    = r_tag[w_up_idx];
        w_ent_target = r_target[w_up_idx];
        w_ent_cnt    = r_cnt[w_up_idx];
        if (bus.ex_upd_valid) begin
            if (bus.ex_upd_is_jalr) begin
                // Indirect targets are not worth caching; drop any stale entry.
                if (w_up_hit) begin
                    w_ent_we    = 1'b1;
                    w_ent_valid = 1'b0;
                end
            end else if (w_up_hit) begin
                w_ent_we = 1'b1;
                if (bus.ex_upd_taken) begin
                    w_ent_cnt    = (r_cnt[w_up_idx] == 2'b11) ? 2'b11 : r_cnt[w_up_idx] + 2'b01;
                    w_ent_target = bus.ex_upd_target[31:2];
                end else begin
                    w_ent_cnt    = (r_cnt[w_up_idx] == 2'b00) ? 2'b00 : r_cnt[w_up_idx] - 2'b01;
                end
            end else if (bus.ex_upd_taken) begin
                w_ent_we     = 1'b1;
                w_ent_valid  = 1'b1;
                w_ent_tag    = w_up_tag;
                w_ent_target = bus.ex_upd_target[31:2];
                w_ent_cnt    = bus.ex_upd_is_jal ? c_cnt_jal : c_cnt_br;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= c_cnt_init;
            end
        end else if (w_ent_we) begin
            r_valid[w_up_idx]  <= w_ent_valid;
            r_tag[w_up_idx]    <= w_ent_tag;
            r_target[w_up_idx] <= w_ent_target;
            r_cnt[w_up_idx]    <= w_ent_cnt;
        end
    end

    // Redirect beats stall; the predicted PC is always word aligned already.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= {RESET_PC[31:2], 2'b00};
        end else if (bus.ex_redirect) begin
            r_pc <= {bus.ex_redirect_pc[31:2], 2'b00};
        end else if (!bus.stall) begin
            r_pc <= w_pred_pc;
        end
    end

    assign bus.if_pc             = r_pc;
    assign bus.predict_taken     = w_pred_taken;
    assign bus.branch_predict_pc = w_pred_pc;

    assign w_unused = ^{bus.ex_redirect_pc[1:0], bus.ex_upd_pc[1:0], bus.ex_upd_target[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_if_pc_bpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_pc_bpu
// Brief    : Directed scoreboard bench for the fetch PC / BTB predictor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_pc_bpu;
    logic clk;
    logic rst;
    int   cyc;
    int   n_total;
    int   n_pass;
    bit   done;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] bpc;
    } exp_t;

    exp_t sb_q[$];

    if_pc_bpu_if bus();

    if_pc_bpu #(
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs are sampled mid-cycle and matched to the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && (sb_q[0].cyc <= cyc || done)) begin
                e = sb_q.pop_front();
                n_total++;
                if (e.cyc != cyc) begin
                    $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
                end else if (bus.if_pc !== e.pc || bus.predict_taken !== e.pt ||
                             bus.branch_predict_pc !== e.bpc) begin
                    $display("FAIL %s: got if_pc=%h pt=%b bpc=%h, required if_pc=%h pt=%b bpc=%h",
                             e.name, bus.if_pc, bus.predict_taken, bus.branch_predict_pc,
                             e.pc, e.pt, e.bpc);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.ex_redirect    = 1'b0;
        bus.ex_redirect_pc = 32'h0;
        bus.ex_upd_valid   = 1'b0;
        bus.ex_upd_pc      = 32'h0;
        bus.ex_upd_taken   = 1'b0;
        bus.ex_upd_target  = 32'h0;
        bus.ex_upd_is_jal  = 1'b0;
        bus.ex_upd_is_jalr = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = pc;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic jal, input logic jalr);
        bus.ex_upd_valid   = 1'b1;
        bus.ex_upd_pc      = pc;
        bus.ex_upd_taken   = taken;
        bus.ex_upd_target  = tgt;
        bus.ex_upd_is_jal  = jal;
        bus.ex_upd_is_jalr = jalr;
    endtask

    // Queue the expected outputs for the current cycle, then advance one edge.
    task automatic step(input string name, input logic [31:0] pc, input logic pt,
                        input logic [31:0] bpc);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.pc   = pc;
        e.pt   = pt;
        e.bpc  = bpc;
        sb_q.push_back(e);
        tick();
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        done      = 1'b0;
        rst       = 1'b1;
        bus.stall = 1'b0;
        clear_in();
        tick();
        tick();
        rst = 1'b0;

        // Reset release, free run, stall, redirect-over-stall (with unaligned pc)
        step("rst_out",  32'h00, 1'b0, 32'h04);
        step("seq_4",    32'h04, 1'b0, 32'h08);
        bus.stall = 1'b1;
        step("seq_8",    32'h08, 1'b0, 32'h0C);
        step("stall_1",  32'h08, 1'b0, 32'h0C);
        step("stall_2",  32'h08, 1'b0, 32'h0C);
        bus.stall = 1'b0;
        step("stall_3",  32'h08, 1'b0, 32'h0C);
        bus.stall = 1'b1;
        redirect(32'h37);
        step("seq_c",    32'h0C, 1'b0, 32'h10);
        bus.stall = 1'b0;
        clear_in();
        step("redir",    32'h34, 1'b0, 32'h38);

        // jal allocation at 0x10 -> 0x20, visible right after its edge
        set_upd(32'h10, 1'b1, 32'h20, 1'b1, 1'b0);
        redirect(32'h10);
        step("pre_jal",  32'h38, 1'b0, 32'h3C);
        clear_in();
        step("jal_hit",  32'h10, 1'b1, 32'h20);
        step("jal_tgt",  32'h20, 1'b0, 32'h24);

        // Conditional branch 0x40 -> 0x80 trained while fetch is stalled at 0x24
        bus.stall = 1'b1;
        set_upd(32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
        step("br_a",     32'h24, 1'b0, 32'h28);
        step("br_b",     32'h24, 1'b0, 32'h28);
        step("br_c",     32'h24, 1'b0, 32'h28);
        clear_in();
        redirect(32'h40);
        step("br_d",     32'h24, 1'b0, 32'h28);
        clear_in();
        step("br_hit",   32'h40, 1'b1, 32'h80);
        set_upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        step("nt_11",    32'h40, 1'b1, 32'h80);
        step("nt_10",    32'h40, 1'b1, 32'h80);
        step("nt_01",    32'h40, 1'b0, 32'h44);
        step("sat_00a",  32'h40, 1'b0, 32'h44);
        set_upd(32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
        step("sat_00b",  32'h40, 1'b0, 32'h44);
        step("up_01",    32'h40, 1'b0, 32'h44);
        clear_in();
        step("up_10",    32'h40, 1'b1, 32'h80);

        // Aliasing on index 0: 0x80 misses, then replaces the 0x40 entry
        redirect(32'h80);
        step("alias_a",  32'h40, 1'b1, 32'h80);
        clear_in();
        set_upd(32'h80, 1'b1, 32'hC0, 1'b0, 1'b0);
        step("alias_mis",32'h80, 1'b0, 32'h84);
        clear_in();
        redirect(32'h40);
        step("alias_new",32'h80, 1'b1, 32'hC0);
        clear_in();
        step("alias_old",32'h40, 1'b0, 32'h44);

        // jalr: invalidates a hit, never allocates on a miss
        set_upd(32'h20, 1'b1, 32'h60, 1'b0, 1'b0);
        redirect(32'h20);
        step("jalr_pre", 32'h40, 1'b0, 32'h44);
        clear_in();
        set_upd(32'h20, 1'b1, 32'h34, 1'b0, 1'b1);
        step("jalr_hit", 32'h20, 1'b1, 32'h60);
        clear_in();
        step("jalr_inv", 32'h20, 1'b0, 32'h24);
        set_upd(32'h50, 1'b1, 32'h34, 1'b0, 1'b1);
        redirect(32'h50);
        step("jalr_m",   32'h20, 1'b0, 32'h24);
        clear_in();
        redirect(32'h10);
        step("jalr_noal",32'h50, 1'b0, 32'h54);
        clear_in();
        step("jal_keep", 32'h10, 1'b1, 32'h20);

        // 32-bit wrap of the sequential next PC
        redirect(32'hFFFF_FFFC);
        step("pre_wrap", 32'h10, 1'b1, 32'h20);
        clear_in();
        bus.stall = 1'b0;
        step("wrap",     32'hFFFF_FFFC, 1'b0, 32'h0);

        // Reset mid-run drops the concurrent update and clears the table
        rst = 1'b1;
        set_upd(32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
        step("pre_rst",  32'h00, 1'b0, 32'h04);
        rst = 1'b0;
        clear_in();
        redirect(32'h10);
        step("rst2",     32'h00, 1'b0, 32'h04);
        clear_in();
        redirect(32'h40);
        step("rst_inv",  32'h10, 1'b0, 32'h14);
        clear_in();
        step("rst_disc", 32'h40, 1'b0, 32'h44);
        step("end",      32'h44, 1'b0, 32'h48);

        done = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
